fetch_stage: RTL and testbench

- Parametrised successor to the single-cycle fetch block.
- Holds the PC and issues reads to an internal synchronous instruction ROM.
- Buffers returned words in a small prefetch FIFO and presents them with a valid/ready handshake to decode.
- Supports PC redirect (branch/jump) with flush, and a sticky fault for misaligned or out-of-range fetch.

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_rom.sv | 37 +++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the fetch stage and its instruction ROM.
package fetch_stage_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] RESET_PC    = 32'h8002_0000;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'b00,
        FAULT_MISALIGNED = 2'b01,
        FAULT_RANGE      = 2'b10
    } fault_reason_e;

endpackage

// File: rtl/fetch_stage_rom.sv
// Single-port synchronous-read instruction ROM with an idle programming port.
module fetch_rom
    import fetch_stage_pkg::*;
#(
    parameter int unsigned data_width = 32,
    parameter int unsigned mem_depth  = 262144,
    parameter int unsigned idx_width  = $clog2(mem_depth)
) (
    input  logic                  clock,
    input  logic                  i_rd_en,
    input  logic [idx_width-1:0]  i_rd_idx,
    output logic [data_width-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [idx_width-1:0]  i_wr_idx,
    input  logic [data_width-1:0] i_wr_data
);

    logic [data_width-1:0] mem [mem_depth];
    logic [data_width-1:0] r_rd_data;

    // Read word is presented one edge after the request and held until the next one.
    always_ff @(posedge clock) begin
        if (i_rd_en) begin
            r_rd_data <= mem[i_rd_idx];
        end
    end

    // Programming port, used only when loading contents.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC sequencing, ROM issue, prefetch FIFO with valid/ready output,
// redirect with flush, and sticky misalignment/range fault.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned              data_width    = 32,
    parameter int unsigned              address_width = 32,
    parameter int unsigned              mem_depth     = 262144,
    parameter logic [address_width-1:0] base_address  = RESET_PC,
    parameter int unsigned              fifo_depth    = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [address_width-1:0] redirect_pc,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [data_width-1:0]    out_instr,
    output logic [address_width-1:0] out_pc,
    output logic                     fault,
    output logic [address_width-1:0] fault_pc
);

    localparam int unsigned        IDX_W     = $clog2(mem_depth);
    localparam int unsigned        PTR_W     = $clog2(fifo_depth);
    localparam logic [63:0]        ROM_BYTES = 64'(mem_depth) << 2;
    localparam logic [PTR_W+1:0]   DEPTH_C   = (PTR_W+2)'(fifo_depth);

    // Offset is taken modulo 2^address_width, so PCs below the base land far out of range.
    function automatic fault_reason_e classify_pc(input logic [address_width-1:0] pc);
        logic [address_width-1:0] offset;
        offset = pc - base_address;
        if (pc[1:0] != 2'b00) begin
            return FAULT_MISALIGNED;
        end else if (64'(offset) >= ROM_BYTES) begin
            return FAULT_RANGE;
        end else begin
            return FAULT_NONE;
        end
    endfunction

    logic [address_width-1:0] r_pc;
    logic                     r_inflight;
    logic [address_width-1:0] r_inflight_pc;
    logic                     r_fault;
    logic [address_width-1:0] r_fault_pc;
    logic [PTR_W:0]           r_wr_ptr;
    logic [PTR_W:0]           r_rd_ptr;
    logic [data_width-1:0]    r_fifo_instr [fifo_depth];
    logic [address_width-1:0] r_fifo_pc    [fifo_depth];

    fault_reason_e            w_fault_reason;
    logic                     w_illegal;
    logic [IDX_W-1:0]         w_rom_idx;
    logic [data_width-1:0]    w_rom_data;
    logic [PTR_W:0]           w_count;
    logic                     w_pop;
    logic                     w_push;
    logic [PTR_W+1:0]         w_occ;
    logic                     w_room;
    logic                     w_try;
    logic                     w_issue;
    logic                     w_raise;

    assign w_fault_reason = classify_pc(r_pc);
    assign w_illegal      = (w_fault_reason != FAULT_NONE);
    assign w_rom_idx      = IDX_W'((r_pc - base_address) >> 2);

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_pop   = out_valid & out_ready;
    assign w_push  = r_inflight & ~redirect_valid;

    // Capacity uses the count after this cycle's pop, so a full FIFO being drained can still issue.
    assign w_occ   = (PTR_W+2)'(w_count) - (PTR_W+2)'(w_pop) + (PTR_W+2)'(r_inflight);
    assign w_room  = (w_occ < DEPTH_C);

    assign w_try   = ~r_fault & ~redirect_valid;
    assign w_issue = w_try & w_room & ~w_illegal;
    assign w_raise = w_try & w_illegal;

    fetch_rom #(
        .data_width (data_width),
        .mem_depth  (mem_depth),
        .idx_width  (IDX_W)
    ) mem_inst (
        .clock     (clock),
        .i_rd_en   (w_issue),
        .i_rd_idx  (w_rom_idx),
        .o_rd_data (w_rom_data),
        .i_wr_en   (1'b0),
        .i_wr_idx  ({IDX_W{1'b0}}),
        .i_wr_data ({data_width{1'b0}})
    );

    // PC, in-flight tracking, FIFO pointers and fault state; redirect overrides everything else.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc          <= base_address;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_fault       <= 1'b0;
            r_fault_pc    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
            r_fault    <= 1'b0;
            r_rd_ptr   <= r_wr_ptr;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= r_pc + address_width'(INSTR_BYTES);
                r_inflight_pc <= r_pc;
            end
            if (w_raise) begin
                r_fault    <= 1'b1;
                r_fault_pc <= r_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1'b1);
            end
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(fifo_depth); i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_fifo_instr[r_wr_ptr[PTR_W-1:0]] <= w_rom_data;
            r_fifo_pc[r_wr_ptr[PTR_W-1:0]]    <= r_inflight_pc;
        end
    end

    assign out_valid = (w_count != '0);
    assign out_instr = r_fifo_instr[r_rd_ptr[PTR_W-1:0]];
    assign out_pc    = r_fifo_pc[r_rd_ptr[PTR_W-1:0]];
    assign fault     = r_fault;
    assign fault_pc  = r_fault_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table, corner sequences, randomized scoreboard.
module tb_fetch_stage;

    localparam logic [31:0] BASE = 32'h8002_0000;

    logic        clock = 1'b0;
    logic        reset_a, reset_b;
    logic        redir_a, rdy_a, redir_b, rdy_b;
    logic [31:0] rpc_a, rpc_b;
    logic        v_a, f_a, v_b, f_b;
    logic [31:0] instr_a, pc_a, fpc_a, instr_b, pc_b, fpc_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    fetch_stage fetch_stage_inst (
        .clock(clock), .reset(reset_a), .redirect_valid(redir_a), .redirect_pc(rpc_a),
        .out_ready(rdy_a), .out_valid(v_a), .out_instr(instr_a), .out_pc(pc_a),
        .fault(f_a), .fault_pc(fpc_a)
    );

    fetch_stage #(.mem_depth(16)) fetch_stage_small (
        .clock(clock), .reset(reset_b), .redirect_valid(redir_b), .redirect_pc(rpc_b),
        .out_ready(rdy_b), .out_valid(v_b), .out_instr(instr_b), .out_pc(pc_b),
        .fault(f_b), .fault_pc(fpc_b)
    );

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_f;
        logic [31:0] exp_fpc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] rom_word(input int unsigned i);
        if (i < 16) return 32'(i);
        else        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] wpc(input int unsigned i);
        return BASE + 32'(i) * 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic add(input logic rdy, input logic redir, input logic [31:0] rpc,
                       input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic f, input logic [31:0] fpc);
        tbl.push_back('{rdy, redir, rpc, v, pc, instr, f, fpc});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc, tgt, prev_pc, prev_instr;
        logic        tgt_legal, prev_v, prev_rdy, prev_redir, pop;
        int          age;

        reset_a = 1'b0; reset_b = 1'b0;
        redir_a = 1'b0; rdy_a = 1'b0; rpc_a = 32'h0;
        redir_b = 1'b0; rdy_b = 1'b0; rpc_b = 32'h0;
        for (int i = 0; i < 4096; i++) fetch_stage_inst.mem_inst.mem[i] = rom_word(i);
        fetch_stage_inst.mem_inst.mem[262143] = rom_word(262143);
        for (int i = 0; i < 16; i++) fetch_stage_small.mem_inst.mem[i] = rom_word(i);

        repeat (3) tick();
        chk("reset out_valid", 32'(v_a), 32'h0);
        chk("reset out_instr", instr_a, 32'h0);
        chk("reset out_pc", pc_a, 32'h0);
        chk("reset fault", 32'(f_a), 32'h0);
        chk("reset fault_pc", fpc_a, 32'h0);
        reset_a = 1'b1;

        // Vector table: one row per edge after reset release.
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int k = 2; k <= 17; k++) add(1'b1, 1'b0, 32'h0, 1'b1, wpc(k-2), rom_word(k-2), 1'b0, 32'h0);
        for (int k = 18; k <= 27; k++) add(1'b0, 1'b0, 32'h0, 1'b1, wpc(15), rom_word(15), 1'b0, 32'h0);
        for (int k = 28; k <= 31; k++) add(1'b1, 1'b0, 32'h0, 1'b1, wpc(k-12), rom_word(k-12), 1'b0, 32'h0);
        add(1'b1, 1'b1, 32'h8002_0040, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b1, wpc(16), rom_word(16), 1'b0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b1, wpc(17), rom_word(17), 1'b0, 32'h0);
        add(1'b1, 1'b1, 32'h8002_0042, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int k = 37; k <= 39; k++) add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8002_0042);
        add(1'b1, 1'b1, BASE, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b1, wpc(0), rom_word(0), 1'b0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b1, wpc(1), rom_word(1), 1'b0, 32'h0);
        add(1'b1, 1'b1, 32'h8012_0000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8012_0000);
        add(1'b1, 1'b1, 32'h8001_FFFC, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8001_FFFC);
        add(1'b1, 1'b1, 32'h8011_FFFC, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b1, 32'h8011_FFFC, rom_word(262143), 1'b1, 32'h8012_0000);
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8012_0000);

        for (int i = 0; i < tbl.size(); i++) begin
            rdy_a = tbl[i].rdy; redir_a = tbl[i].redir; rpc_a = tbl[i].rpc;
            tick();
            chk($sformatf("row%0d out_valid", i), 32'(v_a), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                chk($sformatf("row%0d out_pc", i), pc_a, tbl[i].exp_pc);
                chk($sformatf("row%0d out_instr", i), instr_a, tbl[i].exp_instr);
            end
            chk($sformatf("row%0d fault", i), 32'(f_a), 32'(tbl[i].exp_f));
            if (tbl[i].exp_f) chk($sformatf("row%0d fault_pc", i), fpc_a, tbl[i].exp_fpc);
        end
        redir_a = 1'b0;

        // 16-word ROM: run to the end, then fault while the FIFO is full and drain it.
        reset_b = 1'b1; rdy_b = 1'b1;
        repeat (14) tick();
        chk("small head e14", pc_b, wpc(12));
        rdy_b = 1'b0;
        repeat (3) tick();
        chk("small fault", 32'(f_b), 32'h1);
        chk("small fault_pc", fpc_b, 32'h8002_0040);
        chk("small held head", pc_b, wpc(12));
        rdy_b = 1'b1;
        for (int k = 13; k <= 15; k++) begin
            tick();
            chk($sformatf("small drain pc%0d", k), pc_b, wpc(k));
            chk($sformatf("small drain instr%0d", k), instr_b, rom_word(k));
        end
        repeat (3) tick();
        chk("small drained valid", 32'(v_b), 32'h0);
        chk("small fault sticky", 32'(f_b), 32'h1);

        // Asynchronous reset between edges while valid and fault are both high.
        rdy_a = 1'b0; redir_a = 1'b1; rpc_a = 32'h8011_FFFC;
        tick();
        redir_a = 1'b0;
        repeat (2) tick();
        chk("pre-reset valid", 32'(v_a), 32'h1);
        chk("pre-reset fault", 32'(f_a), 32'h1);
        #3;
        reset_a = 1'b0;
        #1;
        chk("async reset valid", 32'(v_a), 32'h0);
        chk("async reset fault", 32'(f_a), 32'h0);
        chk("async reset out_pc", pc_a, 32'h0);
        chk("async reset fault_pc", fpc_a, 32'h0);
        tick();
        reset_a = 1'b1; rdy_a = 1'b1;
        tick();
        chk("restart e1 valid", 32'(v_a), 32'h0);
        tick();
        chk("restart e2 pc", pc_a, BASE);
        chk("restart e2 instr", instr_a, rom_word(0));
        tick();
        chk("restart e3 pc", pc_a, wpc(1));

        // Randomized traffic against a stream-level scoreboard.
        exp_pc = BASE; tgt = BASE; tgt_legal = 1'b1; age = 0;
        prev_v = 1'b0; prev_rdy = 1'b0; prev_redir = 1'b1; prev_pc = 32'h0; prev_instr = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int unsigned r;
            if (prev_v && !prev_rdy && !prev_redir)
                chk($sformatf("rnd%0d hold", cyc), {v_a, pc_a[30:0]} ^ instr_a,
                    {1'b1, prev_pc[30:0]} ^ prev_instr);
            redir_a = (cyc == 0) || ($urandom_range(0, 15) == 0) || (((exp_pc - BASE) >> 2) > 32'd3500);
            rdy_a = ($urandom_range(0, 3) != 0);
            if (redir_a) begin
                r = $urandom_range(0, 9);
                if (r == 0)      rpc_a = wpc($urandom_range(0, 1000)) + 32'($urandom_range(1, 3));
                else if (r == 1) rpc_a = BASE + 32'h0010_0000 + 32'($urandom_range(0, 1000)) * 32'd4;
                else             rpc_a = wpc($urandom_range(0, 1000));
            end
            pop = v_a && rdy_a && !redir_a;
            if (pop) begin
                chk($sformatf("rnd%0d pop pc", cyc), pc_a, exp_pc);
                chk($sformatf("rnd%0d pop instr", cyc), instr_a, rom_word((exp_pc - BASE) >> 2));
                exp_pc = exp_pc + 32'd4;
            end
            prev_v = v_a; prev_rdy = rdy_a; prev_redir = redir_a; prev_pc = pc_a; prev_instr = instr_a;
            tick();
            if (redir_a) begin
                age = 0; tgt = rpc_a; exp_pc = rpc_a;
                tgt_legal = (rpc_a[1:0] == 2'b00) && ((rpc_a - BASE) < 32'h0010_0000);
            end else begin
                age++;
            end
            if (tgt_legal) begin
                chk($sformatf("rnd%0d valid age%0d", cyc, age), 32'(v_a), 32'(age >= 2));
                chk($sformatf("rnd%0d no fault", cyc), 32'(f_a), 32'h0);
            end else begin
                chk($sformatf("rnd%0d faulted valid", cyc), 32'(v_a), 32'h0);
                chk($sformatf("rnd%0d fault age%0d", cyc, age), 32'(f_a), 32'(age >= 1));
                if (age >= 1) chk($sformatf("rnd%0d fault_pc", cyc), fpc_a, tgt);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
